pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter unit for the fetch stage. It holds the current fetch address and advances it by a fixed instruction size. It can redirect to a target from the PC mux, and it keeps a circular return-address stack (RAS) for call/return. Sticky error flags report stack overflow and underflow to the control unit.

Parameters:
ADDR_WIDTH, 32, width of PC and all addresses
INSTR_BYTES, 4, sequential increment; power of two, at least 1
RESET_VECTOR, 0, PC value loaded at reset
RAS_DEPTH, 4, return-stack entries; power of two, at least 2

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
pcSelect  input  1  advance enable; 0 = stall (hold everything)
loadTarget  input  1  redirect PC to inFromPCMux (jump/branch taken)
callPush  input  1  call: push PC+INSTR_BYTES, redirect to inFromPCMux
retPop  input  1  return: redirect to popped RAS entry
clearErr  input  1  clears sticky error flags
inFromPCMux  input  ADDR_WIDTH  redirect target
addressOut  output  ADDR_WIDTH  current PC (registered)
rasCount  output  $clog2(RAS_DEPTH+1)  valid RAS entries
rasEmpty  output  1  rasCount==0
rasFull  output  1  rasCount==RAS_DEPTH
overflowErr  output  1  sticky: push while full
underflowErr  output  1  sticky: pop while empty

Behaviour:
- reset low, asynchronous: addressOut=RESET_VECTOR, rasCount=0, RAS pointer=0, overflowErr=0, underflowErr=0. RAS data contents are don't-care. rasEmpty=1, rasFull=0.
- All updates occur on the rising clk edge while reset is high. Latency is 1 cycle: the redirect value appears on addressOut the cycle after the command.
- Targets are aligned: the low log2(INSTR_BYTES) bits of any loaded address are forced to 0.
- seq = addressOut + INSTR_BYTES, computed modulo 2^ADDR_WIDTH. It wraps from all-ones region to 0 with no flag.
- pcSelect=0: PC, RAS, count and pointer hold. loadTarget, callPush and retPop are ignored. clearErr still acts.
- pcSelect=1 priority, highest first:
  1. retPop: if count>0, PC = top entry, pointer-1 mod depth, count-1. If count==0, PC = inFromPCMux (fallback), underflowErr=1, count stays 0.
  2. callPush: write seq at pointer, pointer+1 mod depth, PC = inFromPCMux. If count<RAS_DEPTH, count+1. If full, the oldest entry is overwritten, count stays RAS_DEPTH, overflowErr=1.
  3. loadTarget: PC = inFromPCMux, RAS unchanged.
  4. otherwise: PC = seq.
- retPop with callPush in the same cycle: the pop is performed and the push is dropped. This is not an error.
- Error flags:
  - An error set in a cycle takes precedence over clearErr in that same cycle.
  - Flags otherwise stay set until clearErr=1 or reset.
- rasEmpty and rasFull are combinational from rasCount.
- Reset asserted mid-operation abandons the pending command. The next edge after reset release performs normal operation from RESET_VECTOR.
- Top entry is the one at pointer-1 mod depth. Pop after overflow returns the newest entries, LIFO; the overwritten oldest entry is lost.

Test Plan:
- Reset then pcSelect=1 for 3 cycles (defaults) -> addressOut 0x0, 0x4, 0x8, 0xC. Assert reset mid-run -> addressOut=0x0 immediately, without waiting for a clock edge.
- PC=0x100, loadTarget with inFromPCMux=0x2003 -> next addressOut=0x2000 (aligned), rasCount unchanged. Hold pcSelect=0 for 2 cycles with loadTarget high -> PC stays 0x2000.
- PC=0x100, callPush target 0x400 -> PC=0x400, rasCount=1. retPop -> PC=0x104, rasCount=0, rasEmpty=1.
- Five calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4) -> overflowErr=1, rasFull=1. Four pops -> 0x54, 0x44, 0x34, 0x24.
- retPop on empty with inFromPCMux=0x800 -> PC=0x800, underflowErr=1. clearErr -> underflowErr=0 next cycle.
- ADDR_WIDTH=8, PC=0xFC, increment -> PC=0x00. callPush and retPop together with count=1 -> pop taken, rasCount=0, no error.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with sequential advance, redirect, and a
// circular return-address stack that reports sticky overflow/underflow errors.
module pc_sequencer #(
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           INSTR_BYTES  = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned           RAS_DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           pcSelect,
   input  logic                           loadTarget,
   input  logic                           callPush,
   input  logic                           retPop,
   input  logic                           clearErr,
   input  logic [ADDR_WIDTH-1:0]          inFromPCMux,
   output logic [ADDR_WIDTH-1:0]          addressOut,
   output logic [$clog2(RAS_DEPTH+1)-1:0] rasCount,
   output logic                           rasEmpty,
   output logic                           rasFull,
   output logic                           overflowErr,
   output logic                           underflowErr
);

   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] INC        = ADDR_WIDTH'(INSTR_BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(INSTR_BYTES - 1));
   localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(RAS_DEPTH);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [ADDR_WIDTH-1:0] ras_d [RAS_DEPTH];

   logic [ADDR_WIDTH-1:0] seq;
   logic [ADDR_WIDTH-1:0] target;
   logic [PTR_W-1:0]      top_ptr;
   logic                  ovf_set;
   logic                  unf_set;

   assign seq     = pc_q + INC;
   assign target  = inFromPCMux & ALIGN_MASK;
   // Pointer width is exact for a power-of-two depth, so wrap is implicit.
   assign top_ptr = ptr_q - PTR_W'(1);

   always_comb begin
      pc_d    = pc_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ras_d   = ras_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (pcSelect) begin
         if (retPop) begin
            if (cnt_q != '0) begin
               pc_d  = ras_q[top_ptr] & ALIGN_MASK;
               ptr_d = top_ptr;
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               pc_d    = target;
               unf_set = 1'b1;
            end
         end else if (callPush) begin
            ras_d[ptr_q] = seq;
            ptr_d        = ptr_q + PTR_W'(1);
            pc_d         = target;
            if (cnt_q == CNT_MAX) begin
               ovf_set = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else if (loadTarget) begin
            pc_d = target;
         end else begin
            pc_d = seq;
         end
      end
      // A newly detected error wins over a same-cycle clear.
      ovf_d = ovf_set | (ovf_q & ~clearErr);
      unf_d = unf_set | (unf_q & ~clearErr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_VECTOR;
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Stack contents need no reset; validity is tracked by the count.
   always_ff @(posedge clk) begin
      ras_q <= ras_d;
   end

   assign addressOut   = pc_q;
   assign rasCount     = cnt_q;
   assign rasEmpty     = (cnt_q == '0);
   assign rasFull      = (cnt_q == CNT_MAX);
   assign overflowErr  = ovf_q;
   assign underflowErr = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default 32-bit instance and an 8-bit
// instance share stimulus so address wrap can be observed.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        pcSelect, loadTarget, callPush, retPop, clearErr;
   logic [31:0] mux;

   logic [31:0] a_addr;
   logic [2:0]  a_cnt;
   logic        a_empty, a_full, a_ovf, a_unf;
   logic [7:0]  b_addr;
   logic [2:0]  b_cnt;
   logic        b_empty, b_full, b_ovf, b_unf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_sequencer u_a (
      .clk(clk), .reset(reset), .pcSelect(pcSelect), .loadTarget(loadTarget),
      .callPush(callPush), .retPop(retPop), .clearErr(clearErr),
      .inFromPCMux(mux), .addressOut(a_addr), .rasCount(a_cnt),
      .rasEmpty(a_empty), .rasFull(a_full), .overflowErr(a_ovf),
      .underflowErr(a_unf)
   );

   pc_sequencer #(.ADDR_WIDTH(8)) u_b (
      .clk(clk), .reset(reset), .pcSelect(pcSelect), .loadTarget(loadTarget),
      .callPush(callPush), .retPop(retPop), .clearErr(clearErr),
      .inFromPCMux(mux[7:0]), .addressOut(b_addr), .rasCount(b_cnt),
      .rasEmpty(b_empty), .rasFull(b_full), .overflowErr(b_ovf),
      .underflowErr(b_unf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      loadTarget = 1'b0;
      callPush   = 1'b0;
      retPop     = 1'b0;
      clearErr   = 1'b0;
   endtask

   initial begin
      reset    = 1'b0;
      pcSelect = 1'b0;
      mux      = '0;
      idle();
      step();
      step();
      chk("rst_addr", a_addr, 32'h0);
      chk("rst_cnt", {29'd0, a_cnt}, 32'd0);
      chk("rst_empty", {31'd0, a_empty}, 32'd1);
      chk("rst_full", {31'd0, a_full}, 32'd0);
      chk("rst_errs", {30'd0, a_ovf, a_unf}, 32'd0);

      // Sequential advance
      reset    = 1'b1;
      pcSelect = 1'b1;
      step(); chk("seq_4", a_addr, 32'h4);
      step(); chk("seq_8", a_addr, 32'h8);
      step(); chk("seq_c", a_addr, 32'hC);

      // Asynchronous reset away from any clock edge
      #2 reset = 1'b0;
      #1 chk("async_rst", a_addr, 32'h0);
      step();
      reset = 1'b1;
      step(); chk("post_rst", a_addr, 32'h4);

      // Aligned redirect and stall
      loadTarget = 1'b1;
      mux = 32'h100;
      step(); chk("load_100", a_addr, 32'h100);
      mux = 32'h2003;
      step(); chk("load_align", a_addr, 32'h2000);
      chk("load_cnt", {29'd0, a_cnt}, 32'd0);
      pcSelect = 1'b0;
      mux = 32'h3000;
      step(); chk("stall_1", a_addr, 32'h2000);
      step(); chk("stall_2", a_addr, 32'h2000);

      // Call then return
      pcSelect = 1'b1;
      mux = 32'h100;
      step();
      loadTarget = 1'b0;
      callPush = 1'b1;
      mux = 32'h400;
      step(); chk("call_pc", a_addr, 32'h400);
      chk("call_cnt", {29'd0, a_cnt}, 32'd1);
      callPush = 1'b0;
      retPop = 1'b1;
      step(); chk("ret_pc", a_addr, 32'h104);
      chk("ret_cnt", {29'd0, a_cnt}, 32'd0);
      chk("ret_empty", {31'd0, a_empty}, 32'd1);
      idle();

      // Five nested calls overflow a four-entry stack
      for (int k = 1; k <= 5; k++) begin
         loadTarget = 1'b1;
         mux = 32'(k * 16);
         step();
         loadTarget = 1'b0;
         callPush = 1'b1;
         mux = 32'h1000;
         step();
         callPush = 1'b0;
         if (k == 4) begin
            chk("full_4", {31'd0, a_full}, 32'd1);
            chk("noovf_4", {31'd0, a_ovf}, 32'd0);
         end
      end
      chk("ovf_flag", {31'd0, a_ovf}, 32'd1);
      chk("ovf_full", {31'd0, a_full}, 32'd1);
      chk("ovf_cnt", {29'd0, a_cnt}, 32'd4);
      retPop = 1'b1;
      step(); chk("pop_54", a_addr, 32'h54);
      step(); chk("pop_44", a_addr, 32'h44);
      step(); chk("pop_34", a_addr, 32'h34);
      step(); chk("pop_24", a_addr, 32'h24);
      chk("pop_empty", {31'd0, a_empty}, 32'd1);
      chk("ovf_sticky", {31'd0, a_ovf}, 32'd1);
      retPop = 1'b0;
      clearErr = 1'b1;
      step(); chk("ovf_clear", {31'd0, a_ovf}, 32'd0);

      // Underflow with fallback target, then clear, then set-beats-clear
      clearErr = 1'b0;
      retPop = 1'b1;
      mux = 32'h800;
      step(); chk("unf_pc", a_addr, 32'h800);
      chk("unf_flag", {31'd0, a_unf}, 32'd1);
      chk("unf_cnt", {29'd0, a_cnt}, 32'd0);
      retPop = 1'b0;
      clearErr = 1'b1;
      step(); chk("unf_clear", {31'd0, a_unf}, 32'd0);
      chk("unf_clear_pc", a_addr, 32'h804);
      retPop = 1'b1;
      mux = 32'h900;
      step(); chk("unf_beats_clr", {31'd0, a_unf}, 32'd1);
      idle();
      clearErr = 1'b1;
      step();
      clearErr = 1'b0;

      // 8-bit wrap and simultaneous call/return
      loadTarget = 1'b1;
      mux = 32'hFC;
      step(); chk("b_load_fc", {24'd0, b_addr}, 32'hFC);
      loadTarget = 1'b0;
      step(); chk("b_wrap", {24'd0, b_addr}, 32'h00);
      chk("a_nowrap", a_addr, 32'h100);
      callPush = 1'b1;
      mux = 32'h40;
      step(); chk("b_call_pc", {24'd0, b_addr}, 32'h40);
      chk("b_call_cnt", {29'd0, b_cnt}, 32'd1);
      retPop = 1'b1;
      mux = 32'h80;
      step(); chk("b_both_pc", {24'd0, b_addr}, 32'h04);
      chk("a_both_pc", a_addr, 32'h104);
      chk("b_both_cnt", {29'd0, b_cnt}, 32'd0);
      chk("b_both_errs", {30'd0, b_ovf, b_unf}, 32'd0);
      chk("b_both_empty", {31'd0, b_empty}, 32'd1);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
